// File: rtl/sync_fifo_pkg.sv
// Shared types, defaults and helpers for the flexible synchronous FIFO.
// Build option SYNC_FIFO_FWFT_EN selects first-word-fall-through reads.
package sync_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;

   typedef logic [DEF_ADDR_WIDTH:0] count_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for the FIFO: one synchronous write port and
// one asynchronous read port, no reset on the contents.
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   localparam int LP_DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [LP_DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with count, threshold flags, flush and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read mode.
module sync_fifo_flex
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int AF_THRESH  = 14,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam logic [ADDR_WIDTH:0] LP_DEPTH =
      (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] LP_AF = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] LP_AE = (ADDR_WIDTH+1)'(AE_THRESH);
   localparam logic [ADDR_WIDTH:0] LP_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] LP_PINC = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_ovf;
   logic                  r_udf;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_wr_rej;
   logic                  w_rd_rej;
   logic [DATA_WIDTH-1:0] w_ram_rdata;

   // Flags come straight off the registered count, so no lag.
   assign w_full  = (r_count == LP_DEPTH);
   assign w_empty = (r_count == '0);

   // Flush drops both requests without raising errors.
   assign w_wr_acc = wr_en & ~w_full  & ~flush;
   assign w_rd_acc = rd_en & ~w_empty & ~flush;
   assign w_wr_rej = wr_en &  w_full  & ~flush;
   assign w_rd_rej = rd_en &  w_empty & ~flush;

   sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (wr_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + LP_PINC;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + LP_PINC;
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + LP_ONE;
            2'b01:   r_count <= r_count - LP_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // A fresh error outranks a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (w_wr_rej)     r_ovf <= 1'b1;
         else if (err_clr) r_ovf <= 1'b0;
         if (w_rd_rej)     r_udf <= 1'b1;
         else if (err_clr) r_udf <= 1'b0;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rd_data  = w_empty ? '0 : w_ram_rdata;
   assign rd_valid = ~w_empty;
`else
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) r_rd_data <= w_ram_rdata;
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
`endif

   assign count        = r_count;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= LP_AF);
   assign almost_empty = (r_count <= LP_AE);
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex, both read modes.
// Define SYNC_FIFO_FWFT_EN to exercise the FWFT build.
module tb_sync_fifo_flex;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic       overflow;
   logic       underflow;
   logic       err_clr;

   int n_vec;
   int n_err;

   sync_fifo_flex #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (4),
      .AF_THRESH  (14),
      .AE_THRESH  (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow),
      .err_clr      (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pop one word and check it; wr_en is left as the caller set it.
   task automatic pop_chk(input string tag, input logic [7:0] exp_d);
`ifdef SYNC_FIFO_FWFT_EN
      chk({tag, "_vld"}, rd_valid, 1);
      chk({tag, "_dat"}, rd_data, exp_d);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
`else
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk({tag, "_vld"}, rd_valid, 1);
      chk({tag, "_dat"}, rd_data, exp_d);
`endif
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      flush   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      err_clr = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_ae", almost_empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_udf", underflow, 0);
      chk("rst_vld", rd_valid, 0);
      chk("rst_dat", rd_data, 0);
      rst_n = 1'b1;
      tick();

      wr_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_data = 8'(i);
         tick();
         chk("fill_cnt", count, 32'(i + 1));
         chk("fill_full", full, 32'(i == 15));
         chk("fill_af", almost_full, 32'(i + 1 >= 14));
         chk("fill_ae", almost_empty, 32'(i + 1 <= 2));
         chk("fill_empty", empty, 0);
      end
      wr_data = 8'hEE;
      tick();
      wr_en = 1'b0;
      chk("ovf_set", overflow, 1);
      chk("ovf_cnt", count, 16);

      for (int i = 0; i < 16; i++) begin
         pop_chk("drain", 8'(i));
         chk("drain_cnt", count, 32'(15 - i));
      end
      chk("drain_empty", empty, 1);

      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("udf_set", underflow, 1);
      chk("udf_vld", rd_valid, 0);
      chk("udf_cnt", count, 0);

      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_ovf", overflow, 0);
      chk("clr_udf", underflow, 0);

      wr_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wr_data = 8'(8'h10 + k);
         tick();
      end
      chk("five_cnt", count, 5);
      for (int k = 0; k < 40; k++) begin
         wr_data = 8'(8'h15 + k);
         pop_chk("wrap", 8'(8'h10 + k));
         chk("wrap_cnt", count, 5);
      end
      wr_en = 1'b0;
      chk("wrap_ovf", overflow, 0);
      chk("wrap_udf", underflow, 0);

      wr_en = 1'b1;
      for (int k = 0; k < 11; k++) begin
         wr_data = 8'(8'h3D + k);
         tick();
      end
      wr_en = 1'b0;
      chk("full2_cnt", count, 16);
      chk("full2_full", full, 1);

      wr_en   = 1'b1;
      wr_data = 8'hFF;
      pop_chk("fullrw", 8'h38);
      wr_en = 1'b0;
      chk("fullrw_ovf", overflow, 1);
      chk("fullrw_cnt", count, 15);

      for (int k = 0; k < 6; k++) pop_chk("pre_flush", 8'(8'h39 + k));
      chk("nine_cnt", count, 9);

      flush   = 1'b1;
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 8'h77;
      tick();
      flush = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("flush_cnt", count, 0);
      chk("flush_empty", empty, 1);
      chk("flush_ovf", overflow, 1);
      chk("flush_udf", underflow, 0);
      chk("flush_vld", rd_valid, 0);

      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("eclr_ovf", overflow, 0);

      wr_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         wr_data = 8'(8'h80 + k);
         tick();
      end
      chk("full3", full, 1);
      err_clr = 1'b1;
      wr_data = 8'h55;
      tick();
      err_clr = 1'b0;
      wr_en   = 1'b0;
      chk("eclr_win", overflow, 1);
      chk("eclr_cnt", count, 16);

      rst_n = 1'b0;
      #2;
      chk("mrst_cnt", count, 0);
      chk("mrst_empty", empty, 1);
      chk("mrst_ovf", overflow, 0);
      chk("mrst_vld", rd_valid, 0);
      chk("mrst_dat", rd_data, 0);
      wr_en   = 1'b1;
      wr_data = 8'hA5;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      wr_en = 1'b0;
      chk("first_wr_cnt", count, 1);
      chk("first_wr_empty", empty, 0);
`ifdef SYNC_FIFO_FWFT_EN
      chk("fwft_vld", rd_valid, 1);
      chk("fwft_dat", rd_data, 8'hA5);
`else
      chk("std_novld", rd_valid, 0);
`endif
      pop_chk("a5", 8'hA5);
      chk("a5_empty", empty, 1);
      chk("a5_cnt", count, 0);
      tick();
      chk("a5_vld_off", rd_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO with an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags. Full and empty are exact in the same cycle as the occupancy change, with no one-cycle lag. A compile-time option selects first-word-fall-through (FWFT) read mode. It sits between producer and consumer stages in the datapath and replaces the basic FIFO wherever flow-control thresholds or error visibility are needed.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (legal range 1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (legal range 0..DEPTH-1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of contents
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request (pop in FWFT mode)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data qualifier
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- full, empty  out  1 each  count==DEPTH, count==0
- almost_full, almost_empty  out  1 each  threshold flags
- overflow, underflow  out  1 each  sticky error flags
- err_clr  in  1  clears overflow and underflow

## Operation
- Accepted write: wr_acc = wr_en & ~full. The word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
- Accepted read: rd_acc = rd_en & ~empty. rd_ptr increments modulo DEPTH.
- Write while full: the write is rejected, memory and pointers are unchanged, and overflow is set.
- Read while empty: the read is rejected and underflow is set.
- Simultaneous read and write:
  - When full: the read is accepted, the write is rejected, overflow is set, and count becomes DEPTH-1.
  - When empty: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
  - Otherwise: both are accepted and count is unchanged.
- Count update: count += wr_acc - rd_acc, registered at ADDR_WIDTH+1 bits.
- Flag derivation: full, empty, almost_full and almost_empty are decoded from the registered count and change in the same cycle as count.
- Flush: pointers and count go to 0 on the next edge. Flush has priority over wr_en and rd_en in the same cycle; those requests are dropped and do not set the error flags. Memory contents and the error flags are untouched. In standard mode rd_valid is forced to 0 on the next edge.
- Error flags: err_clr clears both flags. If err_clr coincides with a new error event, the new error wins and the flag stays set.
- Reset values: count=0, empty=1, almost_empty=1, full=0, almost_full=0 (AF_THRESH>=1), overflow=0, underflow=0, rd_valid=0, rd_data=0, pointers=0.

## Timing
- Write into an empty FIFO: empty deasserts on the edge after wr_acc, so the write-to-readable latency is 1 cycle.
- Standard mode: rd_data is registered. It is loaded from mem[rd_ptr] on the edge where rd_acc is true, and rd_valid pulses high for one cycle after each rd_acc. rd_data holds its value between reads.
- FWFT mode:
  - rd_data = mem[rd_ptr] through a combinational read, and rd_valid = ~empty.
  - rd_acc consumes the presented word, and the next word appears in the following cycle.
- Pointer wrap: DEPTH-1 to 0 with no bubble. Sustained simultaneous read and write at full throughput is required.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous). The first write is accepted on the first rising edge after rst_n deasserts.

## Configuration
- SYNC_FIFO_FWFT_EN:
  - Defined: FWFT read mode as described in Timing. rd_data shows the head word combinationally whenever empty=0.
  - Undefined: standard mode with a 1-cycle registered read, and rd_valid is a pulse.
- All other behaviour is identical in both builds.

## Structure
- Package sync_fifo_pkg:
  - function clog2
  - typedef for the count width helper
  - localparam defaults: DATA_WIDTH 8, ADDR_WIDTH 4
- Sub-module sync_fifo_ram:
  - DEPTH x DATA_WIDTH register array
  - one synchronous write port and one asynchronous read port
  - instantiated once
- Control logic (pointers, count, flags, errors, output register) lives in sync_fifo_flex.

## Test plan
- Reset, then write 16 words 0x00..0x0F with no reads:
  - full=1 and count=16 on the edge after the 16th write, in the same cycle with no lag
  - almost_full=1 from count=14
  - a 17th write sets overflow, and memory is unchanged
- Drain the 16 words:
  - reads return 0x00..0x0F in order (standard mode: rd_valid one cycle after each rd_en)
  - empty=1 at count 0
  - an extra rd_en sets underflow
- Simultaneous events:
  - with count=5, hold wr_en and rd_en for 40 cycles: count stays 5, the data order is preserved across pointer wrap, and there are no errors
  - repeat at full: overflow is set and count goes 16 to 15
- Flush:
  - with count=9, assert flush together with wr_en and rd_en
  - next cycle: count=0, empty=1, no error flags set, and overflow remains as previously set
- Error clear: with overflow=1, assert err_clr alone and overflow clears next cycle; assert err_clr together with a write while full and overflow stays 1.
- FWFT build:
  - write 0xA5 into an empty FIFO: rd_valid=1 and rd_data=0xA5 one cycle later, with no rd_en needed
  - pulse rd_en and the FIFO returns to empty the next cycle
